spi_slave_regs: RTL and testbench
=================================

Name: spi_slave_regs

Overview:
Fabric-side SPI mode-0 slave that terminates the HPS SPI master conduit (spi_hps_external), giving the HPS register-level read/write access to FPGA logic. SCLK, MOSI and SS_n are oversampled in the system clock domain. Each frame carries an 8-bit command followed by 32 data bits. Decoded writes and reads are presented to the fabric register map over a simple strobe interface.

Parameters:
ADDR_W, 7, register address width (command bits 6:0)
DATA_W, 32, data phase width in bits
SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/SS_n

Ports:
clk_clk  in  1  system clock; f_clk >= 8 x f_sclk
reset_reset_n  in  1  asynchronous active-low reset
spi_sclk  in  1  SPI clock from HPS master, idle low (CPOL=0)
spi_mosi  in  1  master-out data, MSB first
spi_ss_n  in  1  active-low frame select
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  high while spi_ss_n (synchronised) is low
wr_valid  out  1  one-cycle write strobe
wr_addr  out  ADDR_W  write address, held until next wr_valid
wr_data  out  DATA_W  write data, held until next wr_valid
rd_req  out  1  one-cycle read request
rd_addr  out  ADDR_W  read address, held until next rd_req
rd_data  in  DATA_W  read data, must be valid 2 clk after rd_req
frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset: all outputs 0; state WAIT_IDLE; bit counter 0; shift registers 0.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. An SCLK rise or fall and an SS_n rise or fall are single-cycle events.
- Command byte: bit7 = 1 means write, 0 means read; bits 6:0 are the address. All bits are MSB first.
- States:
  - WAIT_IDLE: wait for SS_n high, then go to IDLE. Entered from reset so that a frame already in progress is never decoded.
  - IDLE: SS_n fall -> CMD, counter = 0, MISO = 0.
  - CMD: on each SCLK rise, shift MOSI in and increment the counter. On the 8th rise, latch the command. If it is a read, pulse rd_req with rd_addr in the same cycle. Go to DATA.
  - DATA: for a read, capture rd_data into the TX shifter exactly 2 clk after rd_req. Drive bit 31 on the next SCLK fall, and shift on each subsequent fall. MOSI is shifted into the RX shifter on each rise. On the 40th rise go to DONE.
  - DONE: additional SCLK rises set an overrun flag.
  - Any state except WAIT_IDLE: SS_n rise -> IDLE.
- Frame end (SS_n rise):
  - Counter == 40, write command, no overrun: pulse wr_valid, update wr_addr/wr_data in the same cycle.
  - Counter == 40 and read command: no strobe.
  - Counter != 40 or overrun: pulse frame_err, no wr_valid; rd side effects already issued are not retracted.
  - Counter == 0: silent, no error.
- MISO: 0 during CMD, during write data phase, and in IDLE. MISO changes only on a synchronised SCLK fall.
- Simultaneous SCLK rise and SS_n rise in the same cycle: SS_n has priority and the edge is ignored.
- Reset asserted mid-frame: outputs clear immediately; the block resumes via WAIT_IDLE.

Test Plan:
- Write: SS low, shift 0x85 then 0xDEADBEEF, SS high -> one wr_valid, wr_addr = 0x05, wr_data = 0xDEADBEEF, frame_err = 0.
- Read: shift 0x12, fabric returns 0xCAFE0001 on rd_addr = 0x12 -> rd_req pulses once after the 8th rise; MISO bits 8..39 are 0xCAFE0001 MSB first; no wr_valid.
- Short frame: write command 0x81 plus 20 data bits, SS high -> frame_err pulse, wr_valid stays 0, wr_addr/wr_data keep their previous values.
- Overrun: 41 SCLK rises in a write frame -> frame_err = 1, no wr_valid.
- Reset mid-frame: assert reset_reset_n low after 15 bits with SS_n still low, release, then finish with 25 bits -> no strobes. A following clean write of 0x83/0x00000007 gives wr_addr = 3, wr_data = 7.
- Back-to-back: two write frames separated by 1 SCLK period of SS_n high at f_sclk = f_clk/8 -> two wr_valid pulses with the correct data each.

Source files
------------

// File: rtl/spi_slave_regs.sv
// SPI mode-0 register slave: 8-bit command + 32 data bits, oversampled.
// Ports: clk/reset, SPI pins, wr strobe bus, rd request bus, frame_err.
module spi_slave_regs #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  localparam int CMD_W      = 8;
  localparam int FRAME_BITS = CMD_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FRAME_BITS);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_s, mosi_s, ss_s;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0]  cnt;
  logic [CMD_W-1:0]  cmd_sr, cmd_next;
  logic [DATA_W-1:0] rx_sr, tx_sr;
  logic [1:0]        rd_pipe;
  logic              overrun;

  logic active, frame_end, bit_in, cmd_last;
  logic rd_fire, wr_fire, err_fire, len_ok;
  logic ovr_set, tx_step;

  // Sync chains reset to 0 so a frame already under way at reset
  // never looks like a fresh SS_n fall.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign cmd_next  = {cmd_sr[CMD_W-2:0], mosi_s};

  assign spi_miso_oe = ~ss_s & (state != WAIT_IDLE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= WAIT_IDLE;
    else                state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_IDLE: if (ss_s) state_n = IDLE;
      IDLE:      if (ss_fall) state_n = CMD;
      CMD: begin
        if (ss_rise)       state_n = IDLE;
        else if (cmd_last) state_n = DATA;
      end
      DATA: begin
        if (ss_rise) state_n = IDLE;
        else if (bit_in && cnt == DATA_LAST)
          state_n = DONE;
      end
      DONE:      if (ss_rise) state_n = IDLE;
      default:   state_n = WAIT_IDLE;
    endcase
  end

  // SS_n rise outranks a coincident SCLK edge.
  always_comb begin
    active    = (state == CMD) || (state == DATA)
             || (state == DONE);
    frame_end = active && ss_rise;
    bit_in    = sclk_rise && !ss_rise
             && ((state == CMD) || (state == DATA));
    cmd_last  = bit_in && (state == CMD)
             && (cnt == CMD_LAST);
    rd_fire   = cmd_last && !cmd_next[CMD_W-1];
    len_ok    = (cnt == FULL) && !overrun;
    wr_fire   = frame_end && len_ok && cmd_sr[CMD_W-1];
    err_fire  = frame_end && (cnt != '0) && !len_ok;
    ovr_set   = (state == DONE) && sclk_rise && !ss_rise;
    tx_step   = sclk_fall && !ss_rise
             && ((state == DATA) || (state == DONE));
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
      spi_miso  <= 1'b0;
      cnt       <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rd_pipe   <= '0;
      overrun   <= 1'b0;
    end else begin
      wr_valid  <= wr_fire;
      rd_req    <= rd_fire;
      frame_err <= err_fire;
      rd_pipe   <= {rd_pipe[0], rd_fire};
      if (wr_fire) begin
        wr_addr <= cmd_sr[ADDR_W-1:0];
        wr_data <= rx_sr;
      end
      if (rd_fire) rd_addr <= cmd_next[ADDR_W-1:0];
      if (state == IDLE && ss_fall) begin
        cnt      <= '0;
        cmd_sr   <= '0;
        overrun  <= 1'b0;
        spi_miso <= 1'b0;
      end
      if (frame_end) spi_miso <= 1'b0;
      if (bit_in) begin
        cnt <= cnt + 1'b1;
        if (state == CMD) cmd_sr <= cmd_next;
        else rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
      end
      if (ovr_set) overrun <= 1'b1;
      // Read data lands two clocks after rd_req; write
      // frames keep MISO low whatever the shifter holds.
      if (rd_pipe[1]) begin
        tx_sr <= rd_data;
      end else if (tx_step) begin
        spi_miso <= ~cmd_sr[CMD_W-1] & tx_sr[DATA_W-1];
        tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomised bench for spi_slave_regs with a transaction-level model.
// Drives SPI frames at f_clk/8 and a 2-clock register-map responder.
module tb_spi_slave_regs;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic [31:0] rd_data;
  logic        spi_miso, spi_miso_oe;
  logic        wr_valid, rd_req, frame_err;
  logic [6:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  spi_slave_regs dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_sclk      (sclk),
    .spi_mosi      (mosi),
    .spi_ss_n      (ss_n),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [128];
  wr_t         exp_wr [$];
  logic [6:0]  exp_rd [$];
  int          exp_err = 0;
  wr_t         w;
  logic [6:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  logic [6:0]  m_rd_addr = '0;
  logic [6:0]  ra;
  logic [39:0] word;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Compare process: strobes are matched against the
  // expectation queues, held buses against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_wr_addr = '0;
      m_wr_data = '0;
      m_rd_addr = '0;
      exp_wr.delete();
      exp_rd.delete();
      exp_err = 0;
      check("reset_outs",
            {wr_valid, rd_req, frame_err, spi_miso,
             spi_miso_oe, wr_addr, rd_addr}, 0);
      check("reset_wr_data", wr_data, 0);
    end else begin
      if (wr_valid) begin
        check("wr_valid_expected",
              64'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          m_wr_addr = w.a;
          m_wr_data = w.d;
        end
      end
      check("wr_addr", wr_addr, m_wr_addr);
      check("wr_data", wr_data, m_wr_data);
      if (rd_req) begin
        check("rd_req_expected",
              64'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0)
          m_rd_addr = exp_rd.pop_front();
      end
      check("rd_addr", rd_addr, m_rd_addr);
      if (frame_err) begin
        check("frame_err_expected", 64'(exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  // Register map: data valid only on the 2nd edge after rd_req.
  initial begin
    rd_data = $urandom;
    forever begin
      @(negedge clk);
      if (rst_n && rd_req) begin
        ra = rd_addr;
        @(posedge clk);
        #1 rd_data = mem[ra];
        @(posedge clk);
        #1 rd_data = $urandom;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    @(posedge clk);
    #1 ss_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(HALF);
    m = spi_miso;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic ss_high();
    wait_clk(HALF);
    ss_n = 1'b1;
  endtask

  task automatic frame(input logic [7:0] cmd,
                       input logic [31:0] data,
                       input int nbits,
                       input int gap,
                       output logic [39:0] word_o);
    logic [39:0] tx;
    logic        m;
    wr_t         t;
    tx = {cmd, data};
    word_o = '0;
    if (nbits >= 8 && !cmd[7]) exp_rd.push_back(cmd[6:0]);
    ss_low();
    for (int i = 0; i < nbits; i++) begin
      send_bit(i < 40 ? tx[39-i] : 1'($urandom), m);
      if (i < 40) word_o[39-i] = m;
      if (i == 0) check("miso_oe_frame", spi_miso_oe, 1);
    end
    if (nbits == 40 && cmd[7]) begin
      t.a = cmd[6:0];
      t.d = data;
      exp_wr.push_back(t);
    end else if (nbits != 40 && nbits != 0) begin
      exp_err++;
    end
    ss_high();
    if (nbits >= 40)
      check("miso_word", word_o,
            cmd[7] ? 40'h0 : {8'h0, mem[cmd[6:0]]});
    wait_clk(gap);
    check("miso_oe_idle", spi_miso_oe, 0);
    check("pending",
          64'(exp_wr.size() + exp_rd.size() + exp_err), 0);
  endtask

  initial begin
    logic        m;
    logic [39:0] tx;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[7'h12] = 32'hCAFE0001;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);

    frame(8'h85, 32'hDEADBEEF, 40, 12, word);
    check("wr_addr_lit", wr_addr, 64'h05);
    check("wr_data_lit", wr_data, 64'hDEADBEEF);

    frame(8'h12, 32'h0, 40, 12, word);
    check("rd_addr_lit", rd_addr, 64'h12);
    check("rd_miso_lit", word[31:0], 64'hCAFE0001);

    frame(8'h81, 32'h12345678, 28, 12, word);
    check("short_addr_kept", wr_addr, 64'h05);
    check("short_data_kept", wr_data, 64'hDEADBEEF);

    frame(8'h86, 32'h0BADF00D, 41, 12, word);
    check("ovr_data_kept", wr_data, 64'hDEADBEEF);

    frame(8'h86, 32'h0, 0, 12, word);

    tx = {8'h85, 32'h55AA55AA};
    ss_low();
    for (int i = 0; i < 15; i++) send_bit(tx[39-i], m);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 15; i < 40; i++) begin
      send_bit(tx[39-i], m);
      if (i == 20) check("oe_wait_idle", spi_miso_oe, 0);
    end
    ss_high();
    wait_clk(12);
    check("rst_pending",
          64'(exp_wr.size() + exp_rd.size() + exp_err), 0);
    check("rst_addr_lit", wr_addr, 64'h0);

    frame(8'h83, 32'h00000007, 40, 12, word);
    check("post_rst_addr", wr_addr, 64'h03);
    check("post_rst_data", wr_data, 64'h07);

    frame(8'hA1, 32'h11112222, 40, 2 * HALF, word);
    frame(8'hC4, 32'h33334444, 40, 2 * HALF, word);
    check("b2b_addr_lit", wr_addr, 64'h44);
    check("b2b_data_lit", wr_data, 64'h33334444);

    for (int k = 0; k < 30; k++) begin
      int n;
      n = ($urandom_range(0, 9) < 7)
        ? 40 : int'($urandom_range(0, 44));
      frame(8'($urandom), $urandom, n,
            int'($urandom_range(8, 20)), word);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
